// File: rtl/t05_huff_pkg.sv
// Shared types and node-word layout for the Huffman tree decoder.
package t05_huff_pkg;

  localparam int NODE_W   = 71;
  localparam int LEFT_HI  = 63;
  localparam int LEFT_LO  = 55;
  localparam int RIGHT_HI = 54;
  localparam int RIGHT_LO = 46;

  localparam logic [8:0] NULL_CHILD = 9'h180;

  // Last depth value before the path is considered runaway (128th bit).
  localparam logic [6:0] DEPTH_LAST = 7'd127;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STEP  = 3'd3,
    ST_EMIT  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_e;

endpackage

// File: rtl/t05_huff_decoder.sv
// Huffman tree walker: fetches nodes, consumes one code bit per node, emits leaf chars.
// Optional T05_HD_ERRCHECK_EN adds child-index and path-depth checking with an ERROR state.
module t05_huff_decoder
  import t05_huff_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [6:0]        max_index,
  input  logic [15:0]       total_chars,
  output logic [6:0]        node_addr,
  output logic              node_rd,
  input  logic [NODE_W-1:0] h_element,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [7:0]        char_out,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  // Handshakes: a bit or a char moves on a rising edge where valid && ready are both high;
  // bit_ready is high only in STEP, char_valid only in EMIT, so the two never overlap.

  state_e      state_q, state_d;
  logic [6:0]  index_q, index_d;
  logic [6:0]  root_q, root_d;
  logic [15:0] total_q, total_d;
  logic [15:0] count_q, count_d;
  logic [8:0]  left_q, left_d;
  logic [8:0]  right_q, right_d;
  logic [7:0]  char_q, char_d;
  logic [8:0]  sel_child;
  logic        step_err;
  logic        can_start;

  logic unused_fields;
  assign unused_fields = ^{h_element[70:64], h_element[45:0]};

  // A null right child means a single-character tree: every bit resolves to the left leaf.
  always_comb begin
    sel_child = bit_in ? right_q : left_q;
    if (sel_child == NULL_CHILD) sel_child = left_q;
  end

  assign can_start = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);

`ifdef T05_HD_ERRCHECK_EN
  logic [6:0] depth_q, depth_d;

  always_comb begin
    depth_d = depth_q;
    if (can_start && start) depth_d = '0;
    else if (state_q == ST_STEP && bit_valid) depth_d = sel_child[8] ? depth_q + 7'd1 : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) depth_q <= '0;
    else        depth_q <= depth_d;
  end

  assign step_err = (depth_q == DEPTH_LAST) || (sel_child[8] && (sel_child[6:0] > root_q));
  assign err      = (state_q == ST_ERROR);
`else
  assign step_err = 1'b0;
  assign err      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    root_d  = root_q;
    total_d = total_q;
    count_d = count_q;
    left_d  = left_q;
    right_d = right_q;
    char_d  = char_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          root_d  = max_index;
          index_d = max_index;
          total_d = total_chars;
          count_d = '0;
          state_d = (total_chars == 16'd0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        left_d  = h_element[LEFT_HI:LEFT_LO];
        right_d = h_element[RIGHT_HI:RIGHT_LO];
        state_d = ST_STEP;
      end
      ST_STEP: begin
        if (bit_valid) begin
          if (step_err) begin
            state_d = ST_ERROR;
          end else if (sel_child[8]) begin
            index_d = sel_child[6:0];
            state_d = ST_FETCH;
          end else begin
            char_d  = sel_child[7:0];
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (char_ready) begin
          count_d = count_q + 16'd1;
          if (count_d == total_q) begin
            state_d = ST_DONE;
          end else begin
            index_d = root_q;
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      root_q  <= '0;
      total_q <= '0;
      count_q <= '0;
      left_q  <= '0;
      right_q <= '0;
      char_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      root_q  <= root_d;
      total_q <= total_d;
      count_q <= count_d;
      left_q  <= left_d;
      right_q <= right_d;
      char_q  <= char_d;
    end
  end

  assign node_addr  = index_q;
  assign node_rd    = (state_q == ST_FETCH);
  assign bit_ready  = (state_q == ST_STEP);
  assign char_valid = (state_q == ST_EMIT);
  assign char_out   = char_q;
  assign done       = (state_q == ST_DONE);
  assign busy       = (state_q == ST_FETCH) || (state_q == ST_WAIT) ||
                      (state_q == ST_STEP)  || (state_q == ST_EMIT);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_t05_huff_decoder.sv
// Directed bench for t05_huff_decoder: tree-walk model, char scoreboard, literal pins.
module tb_t05_huff_decoder;
  import t05_huff_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  max_index = '0;
  logic [15:0] total_chars = '0;
  logic [6:0]  node_addr;
  logic        node_rd;
  logic [70:0] h_element = '0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_ready;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_ready = 1'b1;
  logic        done;
  logic        err;
  logic        busy;
  logic [2:0]  state_dbg;

  t05_huff_decoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .max_index(max_index),
    .total_chars(total_chars), .node_addr(node_addr), .node_rd(node_rd),
    .h_element(h_element), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .char_out(char_out), .char_valid(char_valid),
    .char_ready(char_ready), .done(done), .err(err), .busy(busy),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- tree memory ----------------
  logic [70:0] mem [0:127];
  int          rd_cnt = 0;

  always @(posedge clk) h_element <= mem[node_addr];
  always @(negedge clk) if (node_rd) rd_cnt++;

  function automatic logic [70:0] nw(input logic [8:0] l, input logic [8:0] r);
    return {7'd0, l, r, 46'd0};
  endfunction
  function automatic logic [8:0] lf(input logic [7:0] ch);
    return {1'b0, ch};
  endfunction
  function automatic logic [8:0] in(input logic [6:0] idx);
    return {2'b10, idx};
  endfunction

  task automatic load_tree9();
    for (int i = 0; i < 128; i++) mem[i] = nw(lf(8'h3f), lf(8'h3f));
    mem[0] = nw(lf("B"), lf("C"));
    mem[3] = nw(in(7'd0), lf("A"));
    mem[4] = nw(lf("D"), lf("E"));
    mem[5] = nw(lf("F"), lf("G"));
    mem[6] = nw(in(7'd3), in(7'd4));
    mem[7] = nw(lf("J"), in(7'd5));
    mem[8] = nw(in(7'd6), in(7'd7));
  endtask

  // ---------------- scoreboard ----------------
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  // Walk the tree from the root for each bit; leaves produce chars until total is reached.
  task automatic model_run(input int root, input int total, input bit bits[$]);
    int         idx = root;
    int         n = 0;
    logic [8:0] c;
    foreach (bits[i]) begin
      if (n == total) return;
      c = bits[i] ? mem[idx][54:46] : mem[idx][63:55];
      if (c == 9'h180) c = mem[idx][63:55];
      if (c[8]) begin
`ifdef T05_HD_ERRCHECK_EN
        if (int'(c[6:0]) > root) return;
`endif
        idx = int'(c[6:0]);
      end else begin
        exp_q.push_back(c[7:0]);
        n++;
        idx = root;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && char_valid && char_ready) begin
      got_q.push_back(char_out);
      if (exp_q.size() == 0) begin
        check("unexpected_char", {24'd0, char_out}, 32'hffff_ffff);
      end else begin
        check("char_out", {24'd0, char_out}, {24'd0, exp_q.pop_front()});
      end
    end
    if (rst_n && char_valid && bit_ready) check("ready_overlap", 32'd1, 32'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [6:0] mi, input logic [15:0] tc);
    @(negedge clk);
    start = 1'b1; max_index = mi; total_chars = tc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bit(input bit b, output int waits);
    waits = 0;
    @(negedge clk);
    bit_valid = 1'b1; bit_in = b;
    while (!bit_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!bit_ready) check("bit_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 bit_valid = 1'b0;
  endtask

  task automatic send_bits(input bit bits[$]);
    int w;
    foreach (bits[i]) send_bit(bits[i], w);
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done", {31'd0, done}, 32'd1);
  endtask

  // ---------------- directed tests ----------------
  bit b_q[$];
  int base;
  int w;
  int rd0;

  initial begin
    load_tree9();
    repeat (3) @(negedge clk);
    check("reset_outs", {25'd0, node_addr, node_rd, bit_ready, char_valid, done, err, busy},
          32'd0);
    check("reset_char", {24'd0, char_out}, 32'd0);
    check("reset_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    @(negedge clk) rst_n = 1'b1;

    // 9-node tree, two chars; also checks latency, ignored start and the literal chars
    b_q = '{0, 0, 1, 1, 0};
    base = got_q.size();
    do_start(7'd8, 16'd2);
    model_run(8, 2, b_q);
    send_bit(0, w);
    @(negedge clk); start = 1'b1; total_chars = 16'd0;
    @(negedge clk); start = 1'b0;
    check("start_ignored_busy", {31'd0, busy}, 32'd1);
    send_bit(0, w);
    check("bit_latency_waits", w, 32'd0);
    send_bit(1, w);
    @(negedge clk);
    check("char_valid_after_leaf", {31'd0, char_valid}, 32'd1);
    send_bit(1, w);
    send_bit(0, w);
    wait_done();
    check("done_not_busy", {31'd0, busy}, 32'd0);
    check("t1_char0", {24'd0, got_q[base]}, 32'd65);
    check("t1_char1", {24'd0, got_q[base+1]}, 32'd74);
    check("t1_drained", exp_q.size(), 32'd0);

    // single-node tree with null right child
    mem[0] = nw(lf("C"), 9'h180);
    b_q = '{0, 1, 0};
    base = got_q.size();
    do_start(7'd0, 16'd3);
    model_run(0, 3, b_q);
    send_bits(b_q);
    wait_done();
    check("t2_count", got_q.size() - base, 32'd3);
    check("t2_char2", {24'd0, got_q[base+2]}, 32'd67);
    check("t2_drained", exp_q.size(), 32'd0);
    load_tree9();

    // char_ready held low while EMIT
    #1 char_ready = 1'b0;
    b_q = '{0, 0, 1};
    base = got_q.size();
    do_start(7'd8, 16'd1);
    model_run(8, 1, b_q);
    send_bits(b_q);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", {22'd0, char_valid, bit_ready, char_out}, {22'd0, 1'b1, 1'b0, 8'd65});
    end
    @(posedge clk);
    #1 char_ready = 1'b1;
    wait_done();
    check("t3_one_transfer", got_q.size() - base, 32'd1);

    // asynchronous reset mid-path, then a clean run from the root
    b_q = '{0, 0};
    do_start(7'd8, 16'd2);
    send_bits(b_q);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midrun_reset_outs",
             {17'd0, node_addr, node_rd, bit_ready, char_out, char_valid, done, err, busy}, 32'd0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    b_q = '{0, 0, 1, 1, 0};
    base = got_q.size();
    do_start(7'd8, 16'd2);
    model_run(8, 2, b_q);
    send_bits(b_q);
    wait_done();
    check("t4_char0", {24'd0, got_q[base]}, 32'd65);
    check("t4_char1", {24'd0, got_q[base+1]}, 32'd74);

    // out-of-range internal child
    mem[8] = nw(in(7'd6), in(7'd9));
    mem[9] = nw(lf("Z"), lf("Z"));
    base = got_q.size();
    b_q = '{1, 0};
    do_start(7'd8, 16'd1);
    model_run(8, 1, b_q);
    send_bit(1, w);
    repeat (4) @(negedge clk);
`ifdef T05_HD_ERRCHECK_EN
    check("err_set", {31'd0, err}, 32'd1);
    check("err_state", {29'd0, state_dbg}, {29'd0, ST_ERROR});
    check("err_no_char", got_q.size() - base, 32'd0);
`else
    check("err_tied_low", {31'd0, err}, 32'd0);
    send_bit(0, w);
    wait_done();
    check("noerr_char", {24'd0, got_q[base]}, 32'd90);
`endif
    check("t5_drained", exp_q.size(), 32'd0);
    load_tree9();

    // zero-length run
    rd0 = rd_cnt;
    do_start(7'd8, 16'd0);
    check("zero_done", {30'd0, done, err}, 32'd2);
    repeat (3) @(negedge clk);
    check("zero_no_read", rd_cnt - rd0, 32'd0);
    check("zero_done_held", {31'd0, done}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
